doled_decode: RTL and testbench
===============================

Name: doled_decode

Overview:
- Receive side of the wand SPI LED link, consuming the same mosi/sck pair that doled drives.
- Oversamples sck in the system clock domain and reassembles 32-bit words MSB-first.
- Classifies each word as start, LED, end or error, and presents each decoded word with a one-cycle valid strobe.
- Used for on-board loopback checking of dostring_wave output and as the bench monitor for doled.

Parameters:
- WORD_BITS, 32: bits per frame word (fixed protocol width, not intended to change).
- IDLE_TIMEOUT, 1024: clk cycles without an sck rising edge, with a partial word pending, before that word is abandoned.

Ports:
- doled_decode_clk  input  1  system clock.
- doled_decode_reset  input  1  reset, synchronous, active-high.
- mosi  input  1  serial data from the LED driver; asynchronous to doled_decode_clk.
- sck  input  1  serial clock; data is valid on the rising edge.
- frame_valid  output  1  one-cycle pulse; all outputs below are valid while it is high.
- type_out  output  2  word type: 0 start, 1 LED, 2 end, 3 error.
- brightness  output  5  bits 28:24 of an LED word.
- blue_out  output  8  bits 23:16 of an LED word.
- green_out  output  8  bits 15:8 of an LED word.
- red_out  output  8  bits 7:0 of an LED word.
- led_index  output  8  zero-based count of LED words since the last start word.
- aligned  output  1  high while the state machine is in ALIGNED.

Behaviour:
- Reset values: all outputs 0; synchronizer flops 0; shift register 0; bit counter 0; timeout counter 0; state HUNT.
- Reset asserted mid-word discards the partial word and produces no frame_valid.
- Input sync: sck and mosi each pass through 2 flops; a third sck flop holds the previous value.
- Bit event: rise = sck_s2 AND NOT sck_s3. On rise, mosi_s2 shifts into bit 0 of the shift register.
- Input constraint: sck high and low phases must each last at least 2 clk periods. Faster sck is out of scope and undetected.
- Latency: 3 clk edges from the first edge that samples sck high into sck_s1 to frame_valid high.
- Data outputs are registered and hold their value until the next frame_valid.
- State HUNT:
  - Sliding window; every rise is evaluated.
  - If the window after the shift equals 0 (32 zeros): emit START (type 0), led_index <= 0, bit counter <= 0, go ALIGNED.
  - Nothing else is emitted in HUNT, and the timeout is inactive.
- State ALIGNED:
  - Bit counter counts rises from 0 to 31. On the rise with counter 31, the word completes and the counter wraps to 0.
  - Word all zeros: START (type 0), led_index <= 0, stay ALIGNED.
  - Word all ones: END (type 2), go HUNT. All-ones is always END, never LED with brightness 31 and full color.
  - Word bits 31:29 = 3'b111 and not all ones: LED (type 1).
    - brightness/blue_out/green_out/red_out take the word fields.
    - led_index shows this LED's index; it increments after emission and saturates at 255.
  - Any other word: ERROR (type 3), go HUNT.
  - For non-LED types, brightness and color outputs are 0 and led_index holds its value.
- Timeout (ALIGNED only):
  - The counter clears on every rise and increments otherwise.
  - If it reaches IDLE_TIMEOUT while the bit counter is nonzero: emit ERROR (type 3), clear the shift register, go HUNT.
  - If the bit counter is 0 (idle between words), the timeout never fires.
- Simultaneous rise and timeout on the same cycle: the rise wins and the timeout counter clears.
- Only one frame_valid per word; back-to-back words produce strobes 32 sck periods apart.

Decomposition:
- Shared package doled_pkg:
  - word type constants TYPE_START=0, TYPE_LED=1, TYPE_END=2, TYPE_ERROR=3; doled and dostring_wave switch to the same constants.
  - WORD_BITS=32.
  - LED header value 3'b111.
  - decoder state encoding HUNT=0, ALIGNED=1.
- One sub-module, doled_sync_edge: the 2-flop synchronizers for sck and mosi plus the rise detector. Outputs rise and mosi_s2; takes the same clk and reset.
- The decode state machine, counters and output registers stay in doled_decode.

Test Plan:
- Reset mid-word: assert reset after 17 bits of a start word -> no frame_valid; aligned=0; all outputs 0 on the cycle after reset.
- Start word 32'h00000000, then LED 32'hE5_10_20_30, then end 32'hFFFFFFFF, sck at clk/8:
  - start: frame_valid with type 0, led_index 0.
  - LED: type 1, brightness 5, blue 0x10, green 0x20, red 0x30, led_index 0.
  - end: type 2, then aligned=0.
  - Each strobe arrives 3 clk after the sampled last rise.
- Seven LED words after a start (a full dostring_wave string of 6 plus one) -> led_index 0..6 in order. A 300-LED stream saturates at 255.
- Misalignment: 5 bits of 1, then 32 zeros, then one LED word -> only START then LED are emitted, with correct fields.
- Bad header 32'h40000000 while ALIGNED -> type 3, then aligned=0. A following 32 zeros re-align with type 0.
- Stall after 10 bits of an LED word:
  - for IDLE_TIMEOUT-1 cycles -> no strobe.
  - at IDLE_TIMEOUT -> type 3, aligned=0.
  - stall with bit counter 0 for 5000 cycles -> no strobe.

Source files
------------

// File: rtl/doled_pkg.sv
// Shared definitions for the doled SPI LED link: word types, frame width and
// the receive-side decoder state encoding.
package doled_pkg;

    localparam int         WORD_BITS  = 32;
    localparam logic [2:0] LED_HEADER = 3'b111;

    typedef enum logic [1:0] {
        TYPE_START = 2'd0,
        TYPE_LED   = 2'd1,
        TYPE_END   = 2'd2,
        TYPE_ERROR = 2'd3
    } word_type_e;

    typedef enum logic {
        HUNT    = 1'b0,
        ALIGNED = 1'b1
    } dec_state_e;

    // All-ones must be checked before the header so it is never taken as an LED word.
    function automatic word_type_e classify_word(input logic [WORD_BITS-1:0] w);
        if (w == '0) return TYPE_START;
        if (&w) return TYPE_END;
        if (w[WORD_BITS-1 -: 3] == LED_HEADER) return TYPE_LED;
        return TYPE_ERROR;
    endfunction

endpackage

// File: rtl/doled_sync_edge.sv
// Brings sck and mosi into the clk domain and flags each sck rising edge.
module doled_sync_edge (
    input  logic clk,
    input  logic srst,
    input  logic sck,
    input  logic mosi,
    output logic rise,
    output logic mosi_s2
);

    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_s3_q  <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= sck;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign rise    = sck_s2_q & ~sck_s3_q;
    assign mosi_s2 = mosi_s2_q;

endmodule

// File: rtl/doled_decode.sv
// Receive side of the doled SPI LED link: reassembles MSB-first words from the
// oversampled sck/mosi pair and presents each classified word with a strobe.
module doled_decode
    import doled_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic       doled_decode_clk,
    input  logic       doled_decode_reset,
    input  logic       mosi,
    input  logic       sck,
    output logic       frame_valid,
    output logic [1:0] type_out,
    output logic [4:0] brightness,
    output logic [7:0] blue_out,
    output logic [7:0] green_out,
    output logic [7:0] red_out,
    output logic [7:0] led_index,
    output logic       aligned
);

    localparam int               CNT_W    = $clog2(WORD_BITS);
    localparam int               TO_W     = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(IDLE_TIMEOUT);

    logic rise, mosi_s2;

    doled_sync_edge u_sync_edge (
        .clk     (doled_decode_clk),
        .srst    (doled_decode_reset),
        .sck     (sck),
        .mosi    (mosi),
        .rise    (rise),
        .mosi_s2 (mosi_s2)
    );

    dec_state_e           state_q, state_d;
    logic [WORD_BITS-1:0] shift_q, shift_d, word_next;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]      timeout_q, timeout_d;
    logic [7:0]           led_cnt_q, led_cnt_d;
    logic                 frame_valid_q, frame_valid_d;
    word_type_e           type_q, type_d, emit_type;
    logic                 emit;
    logic [4:0]           brightness_q, brightness_d;
    logic [7:0]           blue_q, blue_d, green_q, green_d, red_q, red_d;
    logic [7:0]           led_index_q, led_index_d;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        timeout_d     = timeout_q;
        led_cnt_d     = led_cnt_q;
        frame_valid_d = 1'b0;
        type_d        = type_q;
        brightness_d  = brightness_q;
        blue_d        = blue_q;
        green_d       = green_q;
        red_d         = red_q;
        led_index_d   = led_index_q;
        emit          = 1'b0;
        emit_type     = TYPE_ERROR;
        word_next     = {shift_q[WORD_BITS-2:0], mosi_s2};

        if (rise) begin
            shift_d   = word_next;
            timeout_d = '0;
            if (state_q == HUNT) begin
                if (word_next == '0) begin
                    emit      = 1'b1;
                    emit_type = TYPE_START;
                end
            end else if (bit_cnt_q == LAST_BIT) begin
                emit      = 1'b1;
                emit_type = classify_word(word_next);
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (state_q == ALIGNED) begin
            if (timeout_q != TO_MAX) timeout_d = timeout_q + 1'b1;
            // Only a partially received word can be abandoned; idle gaps are legal.
            if (timeout_q == TO_LAST && bit_cnt_q != '0) begin
                emit      = 1'b1;
                emit_type = TYPE_ERROR;
                shift_d   = '0;
            end
        end

        if (emit) begin
            frame_valid_d = 1'b1;
            type_d        = emit_type;
            brightness_d  = '0;
            blue_d        = '0;
            green_d       = '0;
            red_d         = '0;
            bit_cnt_d     = '0;
            timeout_d     = '0;
            case (emit_type)
                TYPE_START: begin
                    state_d     = ALIGNED;
                    led_index_d = '0;
                    led_cnt_d   = '0;
                end
                TYPE_LED: begin
                    brightness_d = word_next[28:24];
                    blue_d       = word_next[23:16];
                    green_d      = word_next[15:8];
                    red_d        = word_next[7:0];
                    led_index_d  = led_cnt_q;
                    if (led_cnt_q != 8'hFF) led_cnt_d = led_cnt_q + 1'b1;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge doled_decode_clk) begin
        if (doled_decode_reset) begin
            state_q       <= HUNT;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            timeout_q     <= '0;
            led_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            type_q        <= TYPE_START;
            brightness_q  <= '0;
            blue_q        <= '0;
            green_q       <= '0;
            red_q         <= '0;
            led_index_q   <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            timeout_q     <= timeout_d;
            led_cnt_q     <= led_cnt_d;
            frame_valid_q <= frame_valid_d;
            type_q        <= type_d;
            brightness_q  <= brightness_d;
            blue_q        <= blue_d;
            green_q       <= green_d;
            red_q         <= red_d;
            led_index_q   <= led_index_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign type_out    = type_q;
    assign brightness  = brightness_q;
    assign blue_out    = blue_q;
    assign green_out   = green_q;
    assign red_out     = red_q;
    assign led_index   = led_index_q;
    assign aligned     = (state_q == ALIGNED);

endmodule

// File: tb/tb_doled_decode.sv
// Self-checking bench for doled_decode: drives an sck/mosi bit stream and checks
// every strobe (including its arrival cycle) against a word-level reference model.
module tb_doled_decode;

    localparam int IDLE_TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mosi = 1'b0;
    logic       sck = 1'b0;
    logic       frame_valid;
    logic [1:0] type_out;
    logic [4:0] brightness;
    logic [7:0] blue_out, green_out, red_out, led_index;
    logic       aligned;

    doled_decode #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .doled_decode_clk   (clk),
        .doled_decode_reset (rst),
        .mosi               (mosi),
        .sck                (sck),
        .frame_valid        (frame_valid),
        .type_out           (type_out),
        .brightness         (brightness),
        .blue_out           (blue_out),
        .green_out          (green_out),
        .red_out            (red_out),
        .led_index          (led_index),
        .aligned            (aligned)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {cycle, type, brightness, blue, green, red, led_index}
    typedef logic [70:0] ev_t;
    ev_t act_q[$];
    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            act_q.push_back({32'(cyc), type_out, brightness, blue_out, green_out, red_out, led_index});
            $display("frame cyc=%0d type=%0d bri=%0d b=%h g=%h r=%h idx=%0d",
                     cyc, type_out, brightness, blue_out, green_out, red_out, led_index);
        end
    end

    // Reference model: word-level view of the link since the last reset.
    bit          m_al;
    logic [31:0] m_win;
    int          m_bits, m_led, m_shown, m_last;

    function automatic ev_t mk(int t, int ty, logic [31:0] w, int idx);
        if (ty == 1) return {32'(t), 2'(ty), w[28:24], w[23:16], w[15:8], w[7:0], 8'(idx)};
        return {32'(t), 2'(ty), 29'd0, 8'(idx)};
    endfunction

    task automatic model_bit(input bit b, input int t);
        m_win  = {m_win[30:0], b};
        m_last = t;
        if (!m_al) begin
            if (m_win == 32'd0) begin
                m_al = 1; m_bits = 0; m_led = 0; m_shown = 0;
                exp_q.push_back(mk(t, 0, 0, 0));
            end
        end else begin
            m_bits++;
            if (m_bits == 32) begin
                m_bits = 0;
                if (m_win == 32'd0) begin
                    m_led = 0; m_shown = 0;
                    exp_q.push_back(mk(t, 0, 0, 0));
                end else if (m_win == 32'hFFFF_FFFF) begin
                    m_al = 0;
                    exp_q.push_back(mk(t, 2, 0, m_shown));
                end else if (m_win[31:29] == 3'b111) begin
                    m_shown = m_led;
                    exp_q.push_back(mk(t, 1, m_win, m_shown));
                    if (m_led < 255) m_led++;
                end else begin
                    m_al = 0;
                    exp_q.push_back(mk(t, 3, 0, m_shown));
                end
            end
        end
    endtask

    // hp = clk periods per sck phase; the rise is consumed 3 clk after sck goes high.
    task automatic send_bit(input bit b, input int hp);
        mosi = b;
        repeat (hp) @(negedge clk);
        sck = 1'b1;
        model_bit(b, cyc + 3);
        repeat (hp) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int hp);
        for (int i = 31; i >= 0; i--) send_bit(w[i], hp);
    endtask

    task automatic preamble();
        repeat (8) send_bit(1'b1, 4);
    endtask

    function automatic logic [31:0] rand_led();
        logic [31:0] w;
        w = $urandom | 32'hE000_0000;
        if (w == 32'hFFFF_FFFF) w[0] = 1'b0;
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        act_q.delete(); exp_q.delete();
        m_al = 0; m_win = 0; m_bits = 0; m_led = 0; m_shown = 0; m_last = 0;
    endtask

    task automatic test_reset();
        ev_t a, e;
        do_reset();
        preamble();
        send_word(32'd0, 4);
        for (int i = 31; i >= 15; i--) send_bit(1'b1, 4);
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL reset_pre: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL reset_pre: got %h want %h", a, e); end
            end
        end
        // Reset in the middle of a word: one clocked reset edge, then check.
        @(negedge clk); rst = 1'b1; sck = 1'b0;
        @(negedge clk); rst = 1'b0;
        total++;
        if ({frame_valid, type_out, brightness, blue_out, green_out, red_out, led_index} !== 40'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {frame_valid, type_out, brightness, blue_out, green_out, red_out, led_index});
        end
        total++;
        if (aligned !== 1'b0) begin bad++; $display("FAIL reset_aligned: got %b want 0", aligned); end
        repeat (10) @(negedge clk);
        total++;
        if (act_q.size() != 0) begin
            bad++; $display("FAIL reset_strobe: got %0d strobes want 0", act_q.size());
        end
    endtask

    task automatic test_basic();
        ev_t a, e;
        do_reset();
        preamble();
        send_word(32'h0000_0000, 4);
        send_word(32'hE510_2030, 4);
        send_word(32'hFFFF_FFFF, 4);
        repeat (6) @(negedge clk);
        total++;
        if (exp_q.size() != 3) begin bad++; $display("FAIL basic_count: got %0d want 3", exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL basic_strobe: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL basic_strobe: got %h want %h", a, e); end
            end
        end
        total++;
        if (act_q.size() != 0) begin bad++; $display("FAIL basic_extra: got %0d want 0", act_q.size()); end
        total++;
        if (aligned !== 1'b0) begin bad++; $display("FAIL basic_aligned: got %b want 0", aligned); end
    endtask

    task automatic test_led_index();
        ev_t a, e;
        do_reset();
        preamble();
        send_word(32'd0, 4);
        repeat (7) send_word(rand_led(), 4);
        repeat (6) @(negedge clk);
        total++;
        if (m_shown != 6) begin bad++; $display("FAIL led7_model_idx: got %0d want 6", m_shown); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL led7_strobe: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL led7_strobe: got %h want %h", a, e); end
            end
        end
        // Continue the string to 300 LEDs at the fastest legal sck rate.
        repeat (293) send_word(rand_led(), 2);
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL led300_strobe: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL led300_strobe: got %h want %h", a, e); end
            end
        end
        total++;
        if (act_q.size() != 0) begin bad++; $display("FAIL led300_extra: got %0d want 0", act_q.size()); end
        total++;
        if (led_index !== 8'd255) begin bad++; $display("FAIL led300_sat: got %0d want 255", led_index); end
    endtask

    task automatic test_misalign();
        ev_t a, e;
        do_reset();
        repeat (5) send_bit(1'b1, 4);
        send_word(32'd0, 4);
        send_word(rand_led(), 4);
        repeat (6) @(negedge clk);
        total++;
        if (act_q.size() != 2) begin bad++; $display("FAIL misalign_count: got %0d want 2", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL misalign_strobe: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL misalign_strobe: got %h want %h", a, e); end
            end
        end
        act_q.delete();
    endtask

    task automatic test_bad_header();
        ev_t a, e;
        do_reset();
        preamble();
        send_word(32'd0, 4);
        send_word(32'h4000_0000, 4);
        repeat (4) @(negedge clk);
        total++;
        if (aligned !== 1'b0) begin bad++; $display("FAIL badhdr_aligned: got %b want 0", aligned); end
        send_word(32'd0, 4);
        repeat (6) @(negedge clk);
        total++;
        if (aligned !== 1'b1) begin bad++; $display("FAIL badhdr_realign: got %b want 1", aligned); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL badhdr_strobe: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL badhdr_strobe: got %h want %h", a, e); end
            end
        end
        total++;
        if (act_q.size() != 0) begin bad++; $display("FAIL badhdr_extra: got %0d want 0", act_q.size()); end
    endtask

    task automatic test_timeout();
        ev_t a, e;
        logic [31:0] w;
        do_reset();
        preamble();
        send_word(32'd0, 4);
        w = rand_led();
        for (int i = 31; i >= 22; i--) send_bit(w[i], 4);
        while (cyc < m_last + IDLE_TIMEOUT - 1) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL stall_pre: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL stall_pre: got %h want %h", a, e); end
            end
        end
        total++;
        if (act_q.size() != 0) begin bad++; $display("FAIL stall_early: got %0d strobes want 0", act_q.size()); end
        total++;
        if (aligned !== 1'b1) begin bad++; $display("FAIL stall_aligned: got %b want 1", aligned); end
        // The partial word is abandoned once the idle limit is reached.
        exp_q.push_back(mk(m_last + IDLE_TIMEOUT, 3, 0, m_shown));
        m_al = 0; m_win = 0; m_bits = 0;
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL stall_timeout: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL stall_timeout: got %h want %h", a, e); end
            end
        end
        total++;
        if (aligned !== 1'b0) begin bad++; $display("FAIL stall_unaligned: got %b want 0", aligned); end

        do_reset();
        preamble();
        send_word(32'd0, 4);
        send_word(rand_led(), 4);
        repeat (5000) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL idle_strobe: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL idle_strobe: got %h want %h", a, e); end
            end
        end
        total++;
        if (act_q.size() != 0) begin bad++; $display("FAIL idle_extra: got %0d want 0", act_q.size()); end
        total++;
        if (aligned !== 1'b1) begin bad++; $display("FAIL idle_aligned: got %b want 1", aligned); end
    endtask

    task automatic test_random();
        ev_t a, e;
        int r, hp, n;
        do_reset();
        preamble();
        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 9);
            hp = $urandom_range(2, 4);
            if (r <= 1) send_word(32'd0, hp);
            else if (r <= 6) send_word(rand_led(), hp);
            else if (r == 7) send_word(32'hFFFF_FFFF, hp);
            else if (r == 8) send_word($urandom, hp);
            else begin
                n = $urandom_range(1, 31);
                repeat (n) send_bit(1'($urandom), hp);
            end
        end
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (act_q.size() == 0) begin bad++; $display("FAIL random_strobe: got none want %h", e); end
            else begin
                a = act_q.pop_front();
                if (a !== e) begin bad++; $display("FAIL random_strobe: got %h want %h", a, e); end
            end
        end
        total++;
        if (act_q.size() != 0) begin bad++; $display("FAIL random_extra: got %0d want 0", act_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_led_index();
        test_misalign();
        test_bad_header();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
